// File: rtl/pattern_sequencer_mc.sv
// Multi-channel pattern sequencer: round-robin fetch of order/note words from one shared synchronous ROM port.
// Optional macro PATSEQ_LOOP_EN: loop to order 0 at the end-of-song marker instead of halting the channel.
module pattern_sequencer_mc #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 8,
  parameter int MAX_ORDERS = 16,
  parameter int ORDER_BASE = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_CH-1:0]     i_note_stb,
  output logic [NUM_CH-1:0]     o_note_valid,
  output logic [6*NUM_CH-1:0]   o_note_pitch,
  output logic [5*NUM_CH-1:0]   o_note_len,
  output logic [4*NUM_CH-1:0]   o_note_instrument,
  output logic [NUM_CH-1:0]     o_note_rest,
  output logic [NUM_CH-1:0]     o_done,
  output logic [NUM_CH-1:0]     o_overrun,
  output logic [ADDR_W-1:0]     o_rom_addr,
  input  logic [15:0]           i_rom_data
);
  localparam int OW = (MAX_ORDERS > 1) ? $clog2(MAX_ORDERS) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, ORD_ADDR, ORD_DATA, PAT_ADDR, PAT_DATA, OUTPUT} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick, cand;
  logic any_pend;
  logic [NUM_CH-1:0] pending_q, pending_d, in_pat_q, in_pat_d, done_q, done_d, ovr_q, ovr_d;
  logic [NUM_CH-1:0] serving, accept;
  logic [OW-1:0] ord_idx_q [NUM_CH];
  logic [OW-1:0] ord_idx_d [NUM_CH];
  logic [7:0] pat_addr_q [NUM_CH];
  logic [7:0] pat_addr_d [NUM_CH];
  logic [7:0] pat_len_q [NUM_CH];
  logic [7:0] pat_len_d [NUM_CH];
  logic [7:0] pat_cnt_q [NUM_CH];
  logic [7:0] pat_cnt_d [NUM_CH];
  logic [6*NUM_CH-1:0] pitch_q, pitch_d;
  logic [5*NUM_CH-1:0] len_q, len_d;
  logic [4*NUM_CH-1:0] instr_q, instr_d;
  logic [NUM_CH-1:0] rest_q, rest_d;
  logic [ADDR_W-1:0] rom_addr_q;

  // Descending scan so the pending channel closest to rr_q wins.
  always_comb begin
    pick     = rr_q;
    cand     = '0;
    any_pend = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = CW'((int'(rr_q) + i) % NUM_CH);
      if (pending_q[cand]) begin
        pick     = cand;
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    serving = '0;
    if (state_q != IDLE) serving[gnt_q] = 1'b1;
    accept = i_note_stb & ~pending_q & ~serving & ~done_q;
    ovr_d  = i_note_stb & ~accept;
  end

  always_comb begin
    o_rom_addr = rom_addr_q;
    if (state_q == ORD_ADDR)
      o_rom_addr = ADDR_W'(ORDER_BASE) + ADDR_W'(gnt_q) * ADDR_W'(MAX_ORDERS)
                   + ADDR_W'(ord_idx_q[gnt_q]);
    else if (state_q == PAT_ADDR)
      o_rom_addr = ADDR_W'(pat_addr_q[gnt_q]);
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    pending_d    = pending_q | accept;
    in_pat_d     = in_pat_q;
    done_d       = done_q;
    ord_idx_d    = ord_idx_q;
    pat_addr_d   = pat_addr_q;
    pat_len_d    = pat_len_q;
    pat_cnt_d    = pat_cnt_q;
    pitch_d      = pitch_q;
    len_d        = len_q;
    instr_d      = instr_q;
    rest_d       = rest_q;
    o_note_valid = '0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          gnt_d            = pick;
          pending_d[pick]  = 1'b0;
          state_d          = in_pat_q[pick] ? PAT_ADDR : ORD_ADDR;
        end
      end
      ORD_ADDR: state_d = ORD_DATA;
      ORD_DATA: begin
        if (i_rom_data[15:8] != 8'd0) begin
          pat_addr_d[gnt_q] = i_rom_data[7:0];
          pat_len_d[gnt_q]  = i_rom_data[15:8];
          pat_cnt_d[gnt_q]  = 8'd1;
          in_pat_d[gnt_q]   = 1'b1;
          state_d           = PAT_ADDR;
        end else begin
`ifdef PATSEQ_LOOP_EN
          // A marker at entry 0 halts the channel, otherwise the engine would spin forever.
          if (ord_idx_q[gnt_q] != '0) begin
            ord_idx_d[gnt_q] = '0;
            state_d          = ORD_ADDR;
          end else begin
            done_d[gnt_q] = 1'b1;
            state_d       = IDLE;
          end
`else
          done_d[gnt_q] = 1'b1;
          state_d       = IDLE;
`endif
        end
      end
      PAT_ADDR: state_d = PAT_DATA;
      PAT_DATA: begin
        pitch_d[6*int'(gnt_q) +: 6] = i_rom_data[5:0];
        len_d[5*int'(gnt_q) +: 5]   = i_rom_data[10:6];
        instr_d[4*int'(gnt_q) +: 4] = i_rom_data[14:11];
        rest_d[gnt_q]               = i_rom_data[15];
        state_d                     = OUTPUT;
      end
      OUTPUT: begin
        o_note_valid[gnt_q] = 1'b1;
        if (pat_cnt_q[gnt_q] < pat_len_q[gnt_q]) begin
          pat_addr_d[gnt_q] = pat_addr_q[gnt_q] + 8'd1;
          pat_cnt_d[gnt_q]  = pat_cnt_q[gnt_q] + 8'd1;
        end else begin
          in_pat_d[gnt_q]  = 1'b0;
          ord_idx_d[gnt_q] = ord_idx_q[gnt_q] + 1'b1;
        end
        rr_d    = (int'(gnt_q) == NUM_CH - 1) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      pending_q  <= '0;
      in_pat_q   <= '0;
      done_q     <= '0;
      ovr_q      <= '0;
      ord_idx_q  <= '{default: '0};
      pat_addr_q <= '{default: '0};
      pat_len_q  <= '{default: '0};
      pat_cnt_q  <= '{default: '0};
      pitch_q    <= '0;
      len_q      <= '0;
      instr_q    <= '0;
      rest_q     <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      pending_q  <= pending_d;
      in_pat_q   <= in_pat_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      ord_idx_q  <= ord_idx_d;
      pat_addr_q <= pat_addr_d;
      pat_len_q  <= pat_len_d;
      pat_cnt_q  <= pat_cnt_d;
      pitch_q    <= pitch_d;
      len_q      <= len_d;
      instr_q    <= instr_d;
      rest_q     <= rest_d;
      rom_addr_q <= o_rom_addr;
    end
  end

  assign o_note_pitch      = pitch_q;
  assign o_note_len        = len_q;
  assign o_note_instrument = instr_q;
  assign o_note_rest       = rest_q;
  assign o_done            = done_q;
  assign o_overrun         = ovr_q;
endmodule

// File: tb/tb_pattern_sequencer_mc.sv
// Scoreboard bench for pattern_sequencer_mc (2 channels, 2 orders each); adapts to PATSEQ_LOOP_EN.
module tb_pattern_sequencer_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stb;
  logic [1:0]  note_valid, note_rest, done, overrun;
  logic [11:0] note_pitch;
  logic [9:0]  note_len;
  logic [7:0]  note_instr;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] rom [256];

  typedef struct { int ch; int cyc; int pitch; int len; int instr; int rest; } note_t;
  typedef struct { int ch; int cyc; } ev_t;
  note_t exp_q[$];
  ev_t   ovr_exp[$];
  note_t e;
  ev_t   v;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    n_note = 0;

  pattern_sequencer_mc #(.NUM_CH(2), .ADDR_W(8), .MAX_ORDERS(2), .ORDER_BASE(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_note_stb(stb),
    .o_note_valid(note_valid), .o_note_pitch(note_pitch), .o_note_len(note_len),
    .o_note_instrument(note_instr), .o_note_rest(note_rest), .o_done(done),
    .o_overrun(overrun), .o_rom_addr(rom_addr), .i_rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_note(input int ch, input int lat, input int p, input int l, input int ins, input int r);
    exp_q.push_back('{ch, cyc + lat, p, l, ins, r});
  endtask

  task automatic exp_ovr(input int ch);
    ovr_exp.push_back('{ch, cyc + 1});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(note_valid), 0);
    chk({tag, "_pitch"}, int'(note_pitch), 0);
    chk({tag, "_len"}, int'(note_len), 0);
    chk({tag, "_instr"}, int'(note_instr), 0);
    chk({tag, "_rest"}, int'(note_rest), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (note_valid[c]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_note: ch%0d valid at cycle %0d, required no note", c, cyc);
        end else begin
          e = exp_q.pop_front();
          n_note++;
          chk($sformatf("note%0d_ch", n_note), c, e.ch);
          chk($sformatf("note%0d_cycle", n_note), cyc, e.cyc);
          chk($sformatf("note%0d_pitch", n_note), int'(note_pitch[6*c +: 6]), e.pitch);
          chk($sformatf("note%0d_len", n_note), int'(note_len[5*c +: 5]), e.len);
          chk($sformatf("note%0d_instr", n_note), int'(note_instr[4*c +: 4]), e.instr);
          chk($sformatf("note%0d_rest", n_note), int'(note_rest[c]), e.rest);
        end
      end
      if (overrun[c]) begin
        if (ovr_exp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_overrun: ch%0d at cycle %0d, required none", c, cyc);
        end else begin
          v = ovr_exp.pop_front();
          chk("overrun_ch", c, v.ch);
          chk("overrun_cycle", cyc, v.cyc);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[0]     = 16'h0240;  // ch0 order0: len 2 @ 0x40
    rom[1]     = 16'h0000;  // ch0 order1: end-of-song
    rom[2]     = 16'h0150;  // ch1 order0: len 1 @ 0x50
    rom[3]     = 16'h0158;  // ch1 order1: len 1 @ 0x58
    rom[8'h40] = 16'h0C85;  // pitch 5, len 18, instr 1
    rom[8'h41] = 16'h8003;  // pitch 3, rest
    rom[8'h50] = 16'h1A47;  // pitch 7, len 9, instr 3
    rom[8'h58] = 16'hF7FF;  // pitch 63, len 31, instr 14, rest
    rst = 1'b1;
    stb = 2'b00;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Simultaneous strobes from reset: ch0 then ch1, 6 cycles apart.
    exp_note(0, 6, 5, 18, 1, 0);
    exp_note(1, 12, 7, 9, 3, 0);
    stb = 2'b11; tick(); stb = 2'b00;
    repeat (16) tick();

    // Second note of ch0's pattern plus a dropped strobe while pending.
    exp_note(0, 4, 3, 0, 0, 1);
    stb = 2'b01; tick();
    exp_ovr(0);
    stb = 2'b01; tick(); stb = 2'b00;
    repeat (10) tick();

    // rr now points at ch1; ch0 then reaches its end-of-song marker.
    exp_note(1, 6, 63, 31, 14, 1);
`ifdef PATSEQ_LOOP_EN
    exp_note(0, 14, 5, 18, 1, 0);
`endif
    stb = 2'b11; tick(); stb = 2'b00;
    repeat (18) tick();
`ifdef PATSEQ_LOOP_EN
    chk("done_after_marker", int'(done), 0);
    exp_note(0, 4, 3, 0, 0, 1);
    stb = 2'b01; tick(); stb = 2'b00;
    repeat (8) tick();
    exp_note(0, 8, 5, 18, 1, 0);
    stb = 2'b01; tick(); stb = 2'b00;
    repeat (12) tick();
`else
    chk("done_after_marker", int'(done), 1);
    exp_ovr(0);
    stb = 2'b01; tick(); stb = 2'b00;
    repeat (4) tick();
    exp_ovr(0);
    stb = 2'b01; tick(); stb = 2'b00;
    repeat (4) tick();
    chk("done_held", int'(done), 1);
`endif

    // ch1 order index wrapped 1 -> 0.
    exp_note(1, 6, 7, 9, 3, 0);
    stb = 2'b10; tick(); stb = 2'b00;
    repeat (10) tick();

    // Reset while ch1 is in PAT_DATA (cycle T+5) for order1.
    stb = 2'b10; tick(); stb = 2'b00;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    tick(); tick();
    rst = 1'b0;
    tick();

    exp_note(1, 6, 7, 9, 3, 0);
    stb = 2'b10; tick(); stb = 2'b00;
    repeat (10) tick();
    exp_note(0, 6, 5, 18, 1, 0);
    stb = 2'b01; tick(); stb = 2'b00;
    repeat (20) tick();

    chk("notes_outstanding", exp_q.size(), 0);
    chk("overruns_outstanding", ovr_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
